// File: rtl/mux_key_internal_pkg.sv
// -----------------------------------------------------------------------------
// mux_key_internal_pkg
// Shared definitions for the key-lookup multiplexer and its users.
//   PAIR_LEN(key_len, data_len) : width of one {key, data} table pair
//   LB/LH/LW/LBU/LHU            : funct3 load-type keys used by LSU instances
// -----------------------------------------------------------------------------
package mux_key_internal_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  function automatic int PAIR_LEN(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction

endpackage

// File: rtl/mux_key_internal_sign_ext.sv
// -----------------------------------------------------------------------------
// sign_ext
// Purely combinational sign/zero extension of DATA_WIDTH bits to OUT_WIDTH.
//   data     [DATA_WIDTH-1:0] : value to extend
//   sext_en                   : 1 = replicate data MSB, 0 = pad with zeros
//   ext_data [OUT_WIDTH-1:0]  : extended value
// -----------------------------------------------------------------------------
module sign_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  sext_en,
  output logic [OUT_WIDTH-1:0]  ext_data
);

  generate
    if (OUT_WIDTH < DATA_WIDTH) begin : g_bad_width
      $error("sign_ext: OUT_WIDTH must be >= DATA_WIDTH");
    end

    if (OUT_WIDTH > DATA_WIDTH) begin : g_ext
      // Pad bit is the data MSB only when sign extension is requested.
      logic w_pad;
      assign w_pad    = sext_en & data[DATA_WIDTH-1];
      assign ext_data = {{(OUT_WIDTH-DATA_WIDTH){w_pad}}, data};
    end else begin : g_pass
      // Equal widths: nothing to extend, sext_en has no effect.
      logic w_unused_sext;
      assign w_unused_sext = sext_en;
      assign ext_data      = OUT_WIDTH'(data);
    end
  endgenerate

endmodule

// File: rtl/mux_key_internal.sv
// -----------------------------------------------------------------------------
// mux_key_internal
// Parameterised key-lookup multiplexer with width extension and an optional
// registered output (compile-time macro MUX_KEY_OUT_REG_EN).
//   clock, reset (async, active-high), en : output register controls; unused
//                                           when the register is compiled out
//   key         [KEY_LEN-1:0]  : lookup key
//   default_out [DATA_LEN-1:0] : value used when no table key matches
//   lut  [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] : packed {key, data} pairs, pair 0 in
//                                          the least-significant position
//   sext_en                    : 1 = sign extend, 0 = zero extend
//   out  [OUT_LEN-1:0]         : extended selected value
//   hit                        : at least one table key equals key
// -----------------------------------------------------------------------------
module mux_key_internal
  import mux_key_internal_pkg::*;
#(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1,
  parameter int OUT_LEN  = DATA_LEN
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          en,
  input  logic [KEY_LEN-1:0]                            key,
  input  logic [DATA_LEN-1:0]                           default_out,
  input  logic [NR_KEY*PAIR_LEN(KEY_LEN, DATA_LEN)-1:0] lut,
  input  logic                                          sext_en,
  output logic [OUT_LEN-1:0]                            out,
  output logic                                          hit
);

  localparam int PL = PAIR_LEN(KEY_LEN, DATA_LEN);

  generate
    if (OUT_LEN < DATA_LEN) begin : g_bad_out_len
      $error("mux_key_internal: OUT_LEN must be >= DATA_LEN");
    end
    if (NR_KEY < 1) begin : g_bad_nr_key
      $error("mux_key_internal: NR_KEY must be >= 1");
    end
  endgenerate

  logic [NR_KEY-1:0]   w_match;
  logic [DATA_LEN-1:0] w_or_data;
  logic                w_hit;
  logic [DATA_LEN-1:0] w_sel;
  logic [OUT_LEN-1:0]  w_ext;

  // Parallel key compare; matching entries are OR-ed so duplicate keys merge.
  always_comb begin
    w_match   = '0;
    w_or_data = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      w_match[i] = (lut[i*PL+DATA_LEN +: KEY_LEN] == key);
      w_or_data  = w_or_data | ({DATA_LEN{w_match[i]}} & lut[i*PL +: DATA_LEN]);
    end
  end

  assign w_hit = |w_match;
  assign w_sel = w_hit ? w_or_data : default_out;

  sign_ext #(
    .DATA_WIDTH (DATA_LEN),
    .OUT_WIDTH  (OUT_LEN)
  ) u_sign_ext (
    .data     (w_sel),
    .sext_en  (sext_en),
    .ext_data (w_ext)
  );

`ifdef MUX_KEY_OUT_REG_EN
  logic [OUT_LEN-1:0] r_out;
  logic               r_hit;

  // Output register: async clear, loads the lookup result when enabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out <= '0;
      r_hit <= 1'b0;
    end else if (en) begin
      r_out <= w_ext;
      r_hit <= w_hit;
    end else begin
      r_out <= r_out;
      r_hit <= r_hit;
    end
  end

  assign out = r_out;
  assign hit = r_hit;
`else
  // Combinational build: register controls are intentionally left unused.
  logic w_unused_ctrl;
  assign w_unused_ctrl = &{1'b0, clock, reset, en};

  assign out = w_ext;
  assign hit = w_hit;
`endif

endmodule

// File: tb/tb_mux_key_internal.sv
// -----------------------------------------------------------------------------
// tb_mux_key_internal
// Directed bench for mux_key_internal and standalone sign_ext. Works in both
// the combinational build and the MUX_KEY_OUT_REG_EN build.
// -----------------------------------------------------------------------------
module tb_mux_key_internal;

  int checks = 0;
  int errors = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b1;
  logic sext_en = 1'b1;

  always #5 clock = ~clock;

  // Instance 0: five funct3-style keys, 32-bit data, no extension.
  logic [2:0]      key0;
  logic [31:0]     dflt0;
  logic [5*35-1:0] lut0;
  logic [31:0]     out0;
  logic            hit0;

  mux_key_internal #(.NR_KEY(5), .KEY_LEN(3), .DATA_LEN(32), .OUT_LEN(32)) dut0 (
    .clock(clock), .reset(reset), .en(en), .key(key0), .default_out(dflt0),
    .lut(lut0), .sext_en(sext_en), .out(out0), .hit(hit0)
  );

  // Instance 1: duplicate keys whose data must merge by OR.
  logic [2:0]      key1;
  logic [11:0]     dflt1;
  logic [3*15-1:0] lut1;
  logic [11:0]     out1;
  logic            hit1;

  mux_key_internal #(.NR_KEY(3), .KEY_LEN(3), .DATA_LEN(12), .OUT_LEN(12)) dut1 (
    .clock(clock), .reset(reset), .en(en), .key(key1), .default_out(dflt1),
    .lut(lut1), .sext_en(sext_en), .out(out1), .hit(hit1)
  );

  // Instance 2: 8-bit data extended to 32 bits.
  logic [0:0]      key2;
  logic [7:0]      dflt2;
  logic [2*9-1:0]  lut2;
  logic [31:0]     out2;
  logic            hit2;

  mux_key_internal #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(8), .OUT_LEN(32)) dut2 (
    .clock(clock), .reset(reset), .en(en), .key(key2), .default_out(dflt2),
    .lut(lut2), .sext_en(sext_en), .out(out2), .hit(hit2)
  );

  // Standalone extender, 16 -> 32.
  logic [15:0] se_data;
  logic        se_sext;
  logic [31:0] se_out;

  sign_ext #(.DATA_WIDTH(16), .OUT_WIDTH(32)) u_se16 (
    .data(se_data), .sext_en(se_sext), .ext_data(se_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Let the lookup result reach the outputs (one enabled edge when registered).
  task automatic settle();
`ifdef MUX_KEY_OUT_REG_EN
    @(posedge clock);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    lut0  = {3'b101, 32'h55, 3'b100, 32'h44, 3'b010, 32'h33, 3'b001, 32'h22, 3'b000, 32'h11};
    lut1  = {3'b110, 12'hA00, 3'b001, 12'h00F, 3'b001, 12'h0F0};
    lut2  = {1'b1, 8'h80, 1'b0, 8'h7F};
    dflt0 = 32'hDEADBEEF;
    dflt1 = 12'h123;
    dflt2 = 8'h00;
    key0  = 3'b011;
    key1  = 3'b111;
    key2  = 1'b0;
    se_data = 16'h0000;
    se_sext = 1'b0;
    #2;

`ifdef MUX_KEY_OUT_REG_EN
    check("reset_out", out0, 32'h0);
    check("reset_hit", {31'h0, hit0}, 32'h0);
`else
    check("init_default_out", out0, 32'hDEADBEEF);
    check("init_default_hit", {31'h0, hit0}, 32'h0);
`endif

    @(negedge clock);
    reset = 1'b0;

    // Main lookup patterns.
    key0 = 3'b010;
    settle();
    check("key010_out", out0, 32'h33);
    check("key010_hit", {31'h0, hit0}, 32'h1);

    key0 = 3'b101;
    settle();
    check("key101_out", out0, 32'h55);

    key0 = 3'b011;
    settle();
    check("miss_out", out0, 32'hDEADBEEF);
    check("miss_hit", {31'h0, hit0}, 32'h0);

    key1 = 3'b001;
    settle();
    check("dup_or_out", {20'h0, out1}, 32'h0FF);
    check("dup_or_hit", {31'h0, hit1}, 32'h1);

    key1 = 3'b110;
    settle();
    check("dup_tbl_single", {20'h0, out1}, 32'hA00);

    key1 = 3'b111;
    settle();
    check("dup_tbl_miss", {20'h0, out1}, 32'h123);

    key2 = 1'b1; sext_en = 1'b1;
    settle();
    check("sext_80", out2, 32'hFFFFFF80);

    sext_en = 1'b0;
    settle();
    check("zext_80", out2, 32'h00000080);

    key2 = 1'b0; sext_en = 1'b1;
    settle();
    check("sext_7f", out2, 32'h0000007F);

    se_data = 16'h8001; se_sext = 1'b1;
    #1;
    check("se16_sext", se_out, 32'hFFFF8001);
    se_sext = 1'b0;
    #1;
    check("se16_zext", se_out, 32'h00008001);

`ifdef MUX_KEY_OUT_REG_EN
    // One-cycle latency, hold on en=0, asynchronous clear mid-cycle.
    @(negedge clock);
    key0 = 3'b000; en = 1'b1;
    #1;
    check("latency_before_edge", out0, 32'h0000DEADBEEF);
    @(posedge clock); #1;
    check("reg_key000_out", out0, 32'h11);
    check("reg_key000_hit", {31'h0, hit0}, 32'h1);

    @(negedge clock);
    en = 1'b0; key0 = 3'b010;
    @(posedge clock); #1;
    check("hold_en0_out", out0, 32'h11);

    @(negedge clock);
    reset = 1'b1;
    #1;
    check("async_reset_out", out0, 32'h0);
    check("async_reset_hit", {31'h0, hit0}, 32'h0);

    @(negedge clock);
    reset = 1'b0; en = 1'b1;
    @(posedge clock); #1;
    check("post_reset_load", out0, 32'h33);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
